// File: rtl/image_scale_pkg.sv
// Shared types for the scaler datapath: window-generator states and 2x2 quad slice indices.
// Pure declarations; no latency or flow control of its own.
package image_scale_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      FILL     = 2'd1,
      STREAM   = 2'd2
   } state_t;

   localparam int Q_P00   = 0;
   localparam int Q_P01   = 1;
   localparam int Q_P10   = 2;
   localparam int Q_P11   = 3;
   localparam int COORD_W = 16;

endpackage

// File: rtl/image_scale_line_buffer.sv
// One line of pixels, single port, read-before-write; read data appears one clock after en.
// No flow control: the caller gates en, and rd_dat holds while en is low.
module image_scale_line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 640,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wr_dat,
   output logic [DATA_WIDTH-1:0] rd_dat
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;

   always_comb begin
      rd_dat_d = rd_dat_q;
      if (en) begin
         rd_dat_d = mem[addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_dat_q <= '0;
      end else begin
         rd_dat_q <= rd_dat_d;
      end
   end

   // Storage is deliberately left unreset; row 0 of every frame rewrites it.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= wr_dat;
      end
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/image_scale_window_gen.sv
// Turns a raster pixel stream into 2x2 windows for bilinear scaling; window is registered one clock after its p11 pixel.
// Single output register: in_ready = !out_valid || out_ready, so a stalled window blocks input combinationally.
module image_scale_window_gen
   import image_scale_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   in_pixel,
   input  logic                    in_valid,
   input  logic                    in_sof,
   output logic                    in_ready,
   output logic [4*DATA_WIDTH-1:0] pixel_quad,
   output logic [15:0]             x_out,
   output logic [15:0]             y_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_eof
);

   localparam int                 AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

   state_t                state_q, state_d;
   logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0]    cur_x, cur_y;
   logic                  sof_take, take, win, last_px;

   // p00/p10 double as the registered left neighbours of the previous and current row.
   logic [DATA_WIDTH-1:0] p00_q, p00_d, p10_q, p10_d, p11_q, p11_d;
   logic [DATA_WIDTH-1:0] lb_rd;

   logic                  out_valid_q, out_valid_d;
   logic                  out_eof_q, out_eof_d;
   logic [COORD_W-1:0]    x_out_q, x_out_d, y_out_q, y_out_d;

   assign in_ready = !out_valid_q || out_ready;

   always_comb begin
      sof_take = in_valid && in_ready && in_sof;
      take     = in_valid && in_ready && ((state_q != WAIT_SOF) || in_sof);
      cur_x    = sof_take ? '0 : x_q;
      cur_y    = sof_take ? '0 : y_q;
      win      = take && (cur_x != '0) && (cur_y != '0);
      last_px  = (cur_x == X_LAST) && (cur_y == Y_LAST);

      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      p00_d   = p00_q;
      p10_d   = p10_q;
      p11_d   = p11_q;

      if (take) begin
         if (cur_x == X_LAST) begin
            x_d = '0;
            y_d = cur_y + 1'b1;
         end else begin
            x_d = cur_x + 1'b1;
            y_d = cur_y;
         end
         state_d = ((cur_y == '0) && (cur_x != X_LAST)) ? FILL : STREAM;
         if (last_px) begin
            state_d = WAIT_SOF;
            x_d     = '0;
            y_d     = '0;
         end
         p00_d = lb_rd;
         p10_d = p11_q;
         p11_d = in_pixel;
      end

      out_valid_d = out_valid_q;
      out_eof_d   = out_eof_q;
      x_out_d     = x_out_q;
      y_out_d     = y_out_q;
      if (win) begin
         out_valid_d = 1'b1;
         out_eof_d   = last_px;
         x_out_d     = cur_x - 1'b1;
         y_out_d     = cur_y - 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_eof_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= WAIT_SOF;
         x_q         <= '0;
         y_q         <= '0;
         p00_q       <= '0;
         p10_q       <= '0;
         p11_q       <= '0;
         out_valid_q <= 1'b0;
         out_eof_q   <= 1'b0;
         x_out_q     <= '0;
         y_out_q     <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         p00_q       <= p00_d;
         p10_q       <= p10_d;
         p11_q       <= p11_d;
         out_valid_q <= out_valid_d;
         out_eof_q   <= out_eof_d;
         x_out_q     <= x_out_d;
         y_out_q     <= y_out_d;
      end
   end

   // The buffer's read register is the p01 output stage itself.
   image_scale_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .AW         (AW)
   ) u_line_buf (
      .clk    (clk),
      .rst    (rst),
      .en     (take),
      .addr   (cur_x[AW-1:0]),
      .wr_dat (in_pixel),
      .rd_dat (lb_rd)
   );

   assign pixel_quad[Q_P00*DATA_WIDTH +: DATA_WIDTH] = p00_q;
   assign pixel_quad[Q_P01*DATA_WIDTH +: DATA_WIDTH] = lb_rd;
   assign pixel_quad[Q_P10*DATA_WIDTH +: DATA_WIDTH] = p10_q;
   assign pixel_quad[Q_P11*DATA_WIDTH +: DATA_WIDTH] = p11_q;
   assign out_valid = out_valid_q;
   assign out_eof   = out_eof_q;
   assign x_out     = x_out_q;
   assign y_out     = y_out_q;

endmodule

// File: tb/tb_image_scale_window_gen.sv
// Bench for image_scale_window_gen on a 4x3 image with pixel = 4*y + x.
module tb_image_scale_window_gen;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_pixel;
   logic          in_valid;
   logic          in_sof;
   logic          in_ready;
   logic [4*DW-1:0] pixel_quad;
   logic [15:0]   x_out;
   logic [15:0]   y_out;
   logic          out_valid;
   logic          out_ready;
   logic          out_eof;

   typedef struct packed {
      logic [31:0] quad;
      logic [15:0] x;
      logic [15:0] y;
      logic        eof;
   } win_t;

   win_t exp_q[$];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   eof_seen = 0;
   int   waits    = 0;

   image_scale_window_gen #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_pixel   (in_pixel),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_ready   (in_ready),
      .pixel_quad (pixel_quad),
      .x_out      (x_out),
      .y_out      (y_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_eof    (out_eof)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Window whose top-left pixel is (xo,yo); values follow pixel = 4*y + x.
   task automatic push_win(input int xo, input int yo, input bit e);
      win_t          w;
      logic [DW-1:0] p;
      p      = DW'(4 * yo + xo);
      w.quad = {p + 8'd5, p + 8'd4, p + 8'd1, p};
      w.x    = 16'(xo);
      w.y    = 16'(yo);
      w.eof  = e;
      exp_q.push_back(w);
   endtask

   task automatic push_frame();
      for (int yo = 0; yo < H - 1; yo++)
         for (int xo = 0; xo < W - 1; xo++)
            push_win(xo, yo, (xo == W - 2) && (yo == H - 2));
   endtask

   task automatic send_px(input int p, input bit s, input bit rdy);
      int n;
      @(negedge clk);
      out_ready = rdy;
      in_valid  = 1'b1;
      in_pixel  = DW'(p);
      in_sof    = s;
      #1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
         waits++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic send_range(input int first, input int last, input bit sof_first);
      for (int i = first; i <= last; i++)
         send_px(i, sof_first && (i == first), 1'b1);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: compares every window that is handed over.
   initial begin : monitor
      win_t got, e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && out_valid && out_ready) begin
            got = {pixel_quad, x_out, y_out, out_eof};
            if (out_eof) eof_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_window: got quad=%h x=%0d y=%0d eof=%0b, expected none",
                        got.quad, got.x, got.y, got.eof);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_err++;
                  $display("FAIL window: got quad=%h x=%0d y=%0d eof=%0b, expected quad=%h x=%0d y=%0d eof=%0b",
                           got.quad, got.x, got.y, got.eof, e.quad, e.x, e.y, e.eof);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pixel  = '0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_eof", 64'(out_eof), 64'd0);
      chk("rst_quad", 64'(pixel_quad), 64'd0);
      chk("rst_x_out", 64'(x_out), 64'd0);
      chk("rst_y_out", 64'(y_out), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Junk before sof is dropped, then a clean frame.
      for (int i = 0; i < 3; i++) send_px(9, 1'b0, 1'b1);
      push_frame();
      send_range(0, 11, 1'b1);
      idle(4);
      chk("a_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("a_eof_count", 64'(eof_seen), 64'd1);

      // Stall the second window for three cycles.
      push_frame();
      send_range(0, 6, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid  = 1'b0;
         #1;
         chk("b_stall_in_ready", 64'(in_ready), 64'd0);
         chk("b_stall_valid", 64'(out_valid), 64'd1);
         chk("b_stall_quad", 64'(pixel_quad), 64'h06050201);
         chk("b_stall_xy", 64'({x_out, y_out}), 64'h00010000);
      end
      send_range(7, 11, 1'b0);
      idle(4);
      chk("b_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("b_eof_count", 64'(eof_seen), 64'd2);

      // sof re-asserted in the 8th slot aborts the frame and restarts.
      push_win(0, 0, 1'b0);
      push_win(1, 0, 1'b0);
      send_range(0, 6, 1'b1);
      push_frame();
      send_range(0, 11, 1'b1);
      idle(4);
      chk("c_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("c_eof_count", 64'(eof_seen), 64'd3);

      // Reset in row 1 while a window is pending.
      send_range(0, 4, 1'b1);
      send_px(5, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("d_pending_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("d_rst_valid", 64'(out_valid), 64'd0);
      chk("d_rst_quad", 64'(pixel_quad), 64'd0);
      chk("d_rst_xy", 64'({x_out, y_out}), 64'd0);
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      push_frame();
      send_range(0, 11, 1'b1);
      idle(4);
      chk("d_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("d_eof_count", 64'(eof_seen), 64'd4);

      // Two back-to-back frames with no input gaps.
      waits = 0;
      push_frame();
      push_frame();
      send_range(0, 11, 1'b1);
      send_range(0, 11, 1'b1);
      chk("e_no_input_waits", 64'(waits), 64'd0);
      idle(4);
      chk("e_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("e_eof_count", 64'(eof_seen), 64'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/image_scale_window_gen.md
IMAGE_SCALE_WINDOW_GEN -- requirements
Module: image_scale_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, input line length in pixels (>=2).
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, input frame height in lines (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port in_pixel  input  DATA_WIDTH  raster-order source pixel.
REQ-007 SHALL have port in_valid  input  1  in_pixel valid.
REQ-008 SHALL have port in_sof  input  1  marks the first pixel (0,0) of a frame; qualified by in_valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_pixel this cycle.
REQ-010 SHALL have port pixel_quad  output  4*DATA_WIDTH  2x2 window, slice k = [k*DATA_WIDTH +: DATA_WIDTH]; k0=p00 top-left, k1=p01 top-right, k2=p10 bottom-left, k3=p11 bottom-right.
REQ-011 SHALL have port x_out  output  16  window top-left column.
REQ-012 SHALL have port y_out  output  16  window top-left row.
REQ-013 SHALL have port out_valid  output  1  window outputs valid.
REQ-014 SHALL have port out_ready  input  1  downstream interpolator accepts window.
REQ-015 SHALL have port out_eof  output  1  high with the last window of a frame.

Function
REQ-016 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-017 in_ready SHALL equal !out_valid || out_ready (single output register, combinational back-pressure).
REQ-018 States: WAIT_SOF, FILL (row 0), STREAM (rows 1..IMG_HEIGHT-1).
REQ-019 WAIT_SOF: in_ready=1; pixels without in_sof dropped; accepted pixel with in_sof -> stored as (0,0), state FILL.
REQ-020 Column counter x wraps IMG_WIDTH-1 -> 0 and increments row counter y; FILL -> STREAM when row 0 completes.
REQ-021 Each accepted pixel SHALL be written to the line buffer at address x after reading the previous-row value at x (read-before-write).
REQ-022 For an accepted pixel at (x,y) with x>=1 and y>=1, one cycle later out_valid=1, p00=(x-1,y-1), p01=(x,y-1), p10=(x-1,y), p11=(x,y), x_out=x-1, y_out=y-1.
REQ-023 Pixels with x=0 or y=0 SHALL produce no window; each frame yields exactly (IMG_WIDTH-1)*(IMG_HEIGHT-1) windows.
REQ-024 out_eof=1 only on the window for input (IMG_WIDTH-1,IMG_HEIGHT-1); after that pixel state -> WAIT_SOF.
REQ-025 Output registers SHALL hold stable while out_valid&&!out_ready.
REQ-026 Accepted in_sof in FILL/STREAM SHALL abort the frame: counters restart at (0,0) with this pixel, state FILL; a pending output window is still delivered.
REQ-027 Simultaneous output transfer and new input acceptance in one cycle SHALL sustain one window per clock.

Reset
REQ-028 On rst: state WAIT_SOF, x=y=0, out_valid=0, out_eof=0, pixel_quad=0, x_out=0, y_out=0, immediately and asynchronously.
REQ-029 Reset mid-frame SHALL discard the partial frame; line-buffer contents need not be cleared.

Structure
REQ-030 Package image_scale_pkg SHALL hold the state enumeration and quad slice index constants (Q_P00..Q_P11) shared with the bilinear interpolator.
REQ-031 Line storage SHALL be sub-module image_scale_line_buffer: single-port, depth IMG_WIDTH, width DATA_WIDTH, synchronous read-before-write.
REQ-032 Registered left-neighbour pixels (current and previous row) SHALL be held in the top level.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, pixel = 4*y+x)
REQ-033 Full frame, out_ready=1 -> 6 windows; first {0,1,4,5} x_out=0 y_out=0; last {6,7,10,11} x_out=2 y_out=1 out_eof=1.
REQ-034 out_ready low 3 cycles on window 2 -> in_ready low, outputs stable, no window lost or duplicated.
REQ-035 Pixels before first in_sof -> dropped, no out_valid; frame after sof matches REQ-033.
REQ-036 in_sof reasserted at pixel 7 -> partial-frame windows only, then new frame produces 6 windows from restart.
REQ-037 rst asserted mid row 1 -> out_valid low same cycle; next frame yields REQ-033 sequence.
REQ-038 Back-to-back frames, continuous in_valid -> 12 windows, two out_eof pulses, one window per clock in STREAM.
